// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator input front end.
// Holds the debounce state encoding and the default timing/width parameters.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    // 1 ms of stability at a 50 MHz board clock.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int SW_WIDTH_DEFAULT        = 12;

    // Wide enough to hold DEBOUNCE_CYCLES itself, so the compare value always fits.
    function automatic int counter_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/calc_debounce.sv
// One push-button conditioner: two-flop synchronizer, four-state debounce FSM,
// saturating stability counter, debounced level and a single-cycle press strobe.
module calc_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int                CNT_W    = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_meta;
    logic            sync_out;
    debounce_state_t state;
    debounce_state_t state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic            pulse_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // The counter only advances while below CNT_LAST, so it saturates there.
    always_comb begin
        state_next = state;
        count_next = count;
        pulse_next = 1'b0;
        case (state)
            IDLE: begin
                if (sync_out) begin
                    state_next = PRESS_WAIT;
                    count_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_out) begin
                    state_next = IDLE;
                end else if (count == CNT_LAST) begin
                    state_next = HELD;
                    pulse_next = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            HELD: begin
                if (!sync_out) begin
                    state_next = RELEASE_WAIT;
                    count_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_out) begin
                    state_next = HELD;
                end else if (count == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            pulse <= pulse_next;
        end
    end

    // A bounce back out of RELEASE_WAIT keeps the level high.
    assign level = (state == HELD) || (state == RELEASE_WAIT);

endmodule

// File: rtl/calc_input_frontend.sv
// Calculator input front end: debounced Enter/Clear buttons plus a switch
// snapshot (operand in [7:0], opcode in [11:8]) taken on each accepted Enter.
module calc_input_frontend
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SW_WIDTH        = SW_WIDTH_DEFAULT
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                EnterRaw,
    input  logic                ClearRaw,
    input  logic [SW_WIDTH-1:0] SwitchsRaw,
    output logic                Enter,
    output logic                Clear,
    output logic                EnterPulse,
    output logic                ClearPulse,
    output logic [SW_WIDTH-1:0] Switchs,
    output logic                SnapshotValid
);

    logic                enter_pulse_raw;
    logic                clear_pulse_raw;
    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_sync;

    calc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) enter_debounce (
        .clock  (clock),
        .reset_n(reset_n),
        .raw    (EnterRaw),
        .level  (Enter),
        .pulse  (enter_pulse_raw)
    );

    calc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) clear_debounce (
        .clock  (clock),
        .reset_n(reset_n),
        .raw    (ClearRaw),
        .level  (Clear),
        .pulse  (clear_pulse_raw)
    );

    // Clear has priority: a coincident Enter press is discarded entirely.
    assign ClearPulse = clear_pulse_raw;
    assign EnterPulse = enter_pulse_raw & ~clear_pulse_raw;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SwitchsRaw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Switchs       <= '0;
            SnapshotValid <= 1'b0;
        end else if (ClearPulse) begin
            SnapshotValid <= 1'b0;
        end else if (EnterPulse) begin
            Switchs       <= sw_sync;
            SnapshotValid <= 1'b1;
        end
    end

endmodule
